rom_port_arbiter: RTL and testbench

Sequencer and arbiter for the CPU's single shared memory port. It takes word requests from the instruction-fetch side (I) and the load/store side (D), grants one at a time, and drives an Avalon-style read/write master toward the instruction ROM / data memory. It then returns the read data with a one-cycle acknowledge. It sits between the CPU core and the memory bus, and detects misaligned accesses and stuck transfers.

---
 rtl/rom_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: sequencer/arbiter for the CPU's single shared memory port.
// Accepts word requests from the fetch (I) and load/store (D) sides, grants one
// at a time, runs one Avalon-style read or write, then returns a one-cycle ack
// with an error flag for misaligned addresses or stuck (timed-out) transfers.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin between I and D on simultaneous requests
//              undefined -> fixed priority, D always beats I
module rom_port_arbiter #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,

  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t      state;
  owner_t      owner;
  logic [7:0]  wait_cnt;

`ifdef ARB_RR_EN
  owner_t      last_grant;
`endif

  logic        grant_d;
  logic [31:0] win_addr;
  logic        win_read;
  logic        win_misaligned;

  // Winner selection among pending requesters (only consumed in IDLE).
  always_comb begin
    grant_d = 1'b0;
`ifdef ARB_RR_EN
    if (i_req && d_req) begin
      grant_d = (last_grant == OWN_I);
    end else begin
      grant_d = d_req;
    end
`else
    grant_d = d_req;
`endif
  end

  // Request fields of the selected winner.
  always_comb begin
    win_addr       = grant_d ? d_addr : i_addr;
    win_read       = !grant_d || !d_write;
    win_misaligned = (win_addr[1:0] != 2'b00);
  end

  // Main sequencer: arbitration, bus strobes, read capture and ack generation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_I;
      wait_cnt     <= '0;
      m_address    <= RESET_VECTOR;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      i_ack        <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= '0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
`ifdef ARB_RR_EN
      last_grant   <= OWN_I;
`endif
    end else begin
      // Acks and their error flags are single-cycle pulses.
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;

      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner <= grant_d ? OWN_D : OWN_I;
`ifdef ARB_RR_EN
            last_grant <= grant_d ? OWN_D : OWN_I;
`endif
            if (win_misaligned) begin
              // No bus cycle: ack with error straight away, m_* untouched.
              if (grant_d) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                i_ack <= 1'b1;
                i_err <= 1'b1;
              end
              state <= ACK;
            end else begin
              m_address    <= win_addr;
              m_read       <= win_read;
              m_write      <= !win_read;
              m_byteenable <= win_read ? 4'hF : d_byteenable;
              if (!win_read) begin
                m_writedata <= d_wdata;
              end
              wait_cnt <= '0;
              state    <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (!m_waitrequest) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (owner == OWN_D) begin
              if (m_read) begin
                d_rdata <= m_readdata;
              end
              d_ack <= 1'b1;
            end else begin
              if (m_read) begin
                i_rdata <= m_readdata;
              end
              i_ack <= 1'b1;
            end
            state <= ACK;
          end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
            // Stuck transfer: abort, flag error, keep previous rdata.
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (owner == OWN_D) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else begin
              i_ack <= 1'b1;
              i_err <= 1'b1;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ACK: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          m_read  <= 1'b0;
          m_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard testbench for rom_port_arbiter: stimulus pushes expected acks into
// a queue, a negedge monitor pops and compares whenever i_ack/d_ack is seen.
module tb_rom_port_arbiter;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  rom_port_arbiter #(
    .RESET_VECTOR (RV),
    .TIMEOUT      (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_ack         (i_ack),
    .i_err         (i_err),
    .i_rdata       (i_rdata),
    .d_req         (d_req),
    .d_write       (d_write),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_byteenable  (d_byteenable),
    .d_ack         (d_ack),
    .d_err         (d_err),
    .d_rdata       (d_rdata),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Monitor: compare every ack against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && (i_ack || d_ack)) begin
      if (i_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_i_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_side_i", 32'(e.is_d), 32'd0);
          check("i_err", 32'(i_err), 32'(e.err));
          check("i_rdata", i_rdata, e.rdata);
        end
      end
      if (d_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_d_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_side_d", 32'(e.is_d), 32'd1);
          check("d_err", 32'(d_err), 32'(e.err));
          check("d_rdata", d_rdata, e.rdata);
        end
      end
    end
  end

  // One transaction on one side; checks latency, strobe length and bus stability.
  task automatic do_txn(input string name, input bit is_d, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] bus_rdata,
                        input int stalls, input int exp_lat, input int exp_strobe,
                        input bit exp_err);
    int lat = 0;
    int strobe = 0;
    int stl = stalls;
    bit seen = 0;
    if (!exp_err && !wr) begin
      if (is_d) exp_d_rdata = bus_rdata;
      else      exp_i_rdata = bus_rdata;
    end
    push(is_d, exp_err, is_d ? exp_d_rdata : exp_i_rdata);
    m_readdata = bus_rdata;
    if (is_d) begin
      d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (!seen && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (m_read || m_write) begin
        strobe++;
        check({name, "_m_address"}, m_address, addr);
        check({name, "_m_write"}, 32'(m_write), 32'(wr));
        check({name, "_m_byteenable"}, 32'(m_byteenable), wr ? 32'(be) : 32'hF);
        if (wr) check({name, "_m_writedata"}, m_writedata, wdata);
        m_waitrequest = (stl > 0);
        if (stl > 0) stl--;
      end else begin
        m_waitrequest = 1'b0;
      end
      if (is_d ? d_ack : i_ack) seen = 1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    m_waitrequest = 1'b0;
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_strobe_cycles"}, 32'(strobe), 32'(exp_strobe));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_m_address", m_address, RV);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_m_byteenable", 32'(m_byteenable), 32'd0);
    check("rst_acks", 32'({i_ack, i_err, d_ack, d_err}), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);

    // Fetch at the reset vector, no wait states.
    do_txn("fetch", 0, 0, 32'hBFC00000, '0, 4'h0, 32'h3C011234, 0, 2, 1, 0);
    // Store with 3 wait cycles.
    do_txn("store", 1, 1, 32'h00001000, 32'hDEADBEEF, 4'b0011, '0, 3, 5, 4, 0);
    // Misaligned load: error ack after one edge, no bus cycle.
    do_txn("mis_d", 1, 0, 32'h00001002, '0, 4'h0, 32'h55555555, 0, 1, 0, 1);
    check("mis_d_m_address_kept", m_address, 32'h00001000);
    // Misaligned fetch.
    do_txn("mis_i", 0, 0, 32'hBFC00001, '0, 4'h0, 32'h66666666, 0, 1, 0, 1);
    // Stuck bus: timeout after 4 stalled cycles, rdata kept.
    do_txn("tmo", 0, 0, 32'hBFC00004, '0, 4'h0, 32'h77777777, 1000, 5, 4, 1);
    // Load with one wait cycle.
    do_txn("load", 1, 0, 32'h00000040, '0, 4'h0, 32'hCAFEF00D, 1, 3, 2, 0);

    // Contention: both sides keep requesting; the side acked second drops.
    do_reset();
    m_readdata = 32'h11110000;
`ifdef ARB_RR_EN
    push(1, 0, 32'h11110000);
    push(0, 0, 32'h11110000);
    push(1, 0, 32'h11110000);
`else
    push(1, 0, 32'h11110000);
    push(1, 0, 32'h11110000);
    push(0, 0, 32'h11110000);
`endif
    i_addr = 32'h00000100; d_addr = 32'h00000200; d_write = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) begin
        n++;
        if (n == 2) begin
          if (i_ack) i_req = 1'b0;
          else       d_req = 1'b0;
        end else if (n == 3) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("contend_ack_count", 32'(n), 32'd3);
    @(negedge clk);

    // Reset in the second ACCESS cycle abandons the transfer without an ack.
    i_addr = 32'h00002000; i_req = 1'b1; m_waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_m_read_before", 32'(m_read), 32'd1);
    check("abort_m_address_before", m_address, 32'h00002000);
    reset_n = 1'b0;
    @(negedge clk);
    i_req = 1'b0; m_waitrequest = 1'b0;
    check("abort_m_read", 32'(m_read), 32'd0);
    check("abort_m_address", m_address, RV);
    check("abort_i_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_ack", 32'({i_ack, d_ack}), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
